contador_bcd_mux: RTL and testbench

Multi-digit BCD up/down counter with time-multiplexed digit scan; the stage directly upstream of the 7-segment encoder. Counts decimal values 0..10^DIGITS−1 at a prescaled rate. Presents one digit at a time on a 4-bit BCD bus together with a one-hot digit select, so a single encoder instance drives all display positions.

---
 rtl/display_pkg.sv | 13 +
 rtl/bcd_digit.sv | 37 +++
 rtl/contador_bcd_mux.sv | 96 +++++++++
 tb/tb_contador_bcd_mux.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared BCD/display constants used by the counter/scan stage and the 7-segment encoder.
// The saturating helper clamps out-of-range nibbles to the largest decimal digit.
package display_pkg;

   localparam int         BCD_WIDTH = 4;
   localparam logic [3:0] BCD_MAX   = 4'd9;
   localparam int         SEG_WIDTH = 7;

   function automatic logic [BCD_WIDTH-1:0] bcd_sat(input logic [BCD_WIDTH-1:0] value);
      return (value > BCD_MAX) ? BCD_MAX : value;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the BCD counter: steps only when its carry-in is set.
// Carry-out ripples into the next decade.
module bcd_digit
   import display_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 step,
   input  logic                 up,
   input  logic                 clear,
   input  logic                 load,
   input  logic [BCD_WIDTH-1:0] load_val,
   input  logic                 carry_in,
   output logic [BCD_WIDTH-1:0] digit,
   output logic                 carry_out
);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         digit <= '0;
      end else if (clear) begin
         digit <= '0;
      end else if (load) begin
         digit <= bcd_sat(load_val);
      end else if (step && carry_in) begin
         if (up) begin
            digit <= (digit == BCD_MAX) ? '0 : digit + 1'b1;
         end else begin
            digit <= (digit == '0) ? BCD_MAX : digit - 1'b1;
         end
      end
   end

   // A decade passes the step on only when it wraps in the current direction.
   assign carry_out = carry_in && (up ? (digit == BCD_MAX) : (digit == '0));

endmodule

// File: rtl/contador_bcd_mux.sv
// Multi-digit BCD up/down counter with prescaled stepping and a time-multiplexed
// digit scan that feeds a single 7-segment encoder.
module contador_bcd_mux
   import display_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int TICK_DIV = 50_000_000,
   parameter int SCAN_DIV = 50_000
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        en,
   input  logic                        up,
   input  logic                        clear,
   input  logic                        load,
   input  logic [BCD_WIDTH*DIGITS-1:0] load_val,
   output logic [BCD_WIDTH*DIGITS-1:0] count,
   output logic                        carry,
   output logic [BCD_WIDTH-1:0]        bcd,
   output logic [DIGITS-1:0]           digit_sel
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [TW-1:0]   tick_cnt;
   logic [SW-1:0]   scan_cnt;
   logic [IW-1:0]   scan_idx;
   logic            tick_last;
   logic            scan_last;
   logic            step;
   logic [DIGITS:0] chain;

   assign tick_last = (tick_cnt == TW'(TICK_DIV - 1));
   assign scan_last = (scan_cnt == SW'(SCAN_DIV - 1));
   assign step      = en && tick_last && !clear && !load;
   assign chain[0]  = 1'b1;

   // Step prescaler: holds while disabled, restarts whenever the count is overwritten.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tick_cnt <= '0;
      end else if (clear || load) begin
         tick_cnt <= '0;
      end else if (en) begin
         tick_cnt <= tick_last ? '0 : tick_cnt + 1'b1;
      end
   end

   genvar i;
   generate
      for (i = 0; i < DIGITS; i++) begin : g_digit
         bcd_digit u_digit (
            .clk       (clk),
            .reset_n   (reset_n),
            .step      (step),
            .up        (up),
            .clear     (clear),
            .load      (load),
            .load_val  (load_val[i*BCD_WIDTH +: BCD_WIDTH]),
            .carry_in  (chain[i]),
            .digit     (count[i*BCD_WIDTH +: BCD_WIDTH]),
            .carry_out (chain[i+1])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         carry <= 1'b0;
      end else begin
         carry <= step && chain[DIGITS];
      end
   end

   // Scan runs freely; BCD and select are both taken from the current index so they never skew.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         scan_cnt  <= '0;
         scan_idx  <= '0;
         bcd       <= '0;
         digit_sel <= DIGITS'(1);
      end else begin
         if (scan_last) begin
            scan_cnt <= '0;
            scan_idx <= (scan_idx == IW'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
         end else begin
            scan_cnt <= scan_cnt + 1'b1;
         end
         bcd       <= count[scan_idx*BCD_WIDTH +: BCD_WIDTH];
         digit_sel <= DIGITS'(1) << scan_idx;
      end
   end

endmodule

// File: tb/tb_contador_bcd_mux.sv
// Directed bench for contador_bcd_mux with DIGITS=4, TICK_DIV=4, SCAN_DIV=2:
// a vector table for control/wrap behaviour plus sequences for counting, scan and reset.
module tb_contador_bcd_mux;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        en;
   logic        up;
   logic        clear;
   logic        load;
   logic [15:0] load_val;
   logic [15:0] count;
   logic        carry;
   logic [3:0]  bcd;
   logic [3:0]  digit_sel;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        rst_n;
      logic        en;
      logic        up;
      logic        clear;
      logic        load;
      logic [15:0] load_val;
      logic [15:0] exp_count;
      logic        exp_carry;
   } vec_t;

   vec_t vecs[$];

   contador_bcd_mux #(
      .DIGITS   (4),
      .TICK_DIV (4),
      .SCAN_DIV (2)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .en        (en),
      .up        (up),
      .clear     (clear),
      .load      (load),
      .load_val  (load_val),
      .count     (count),
      .carry     (carry),
      .bcd       (bcd),
      .digit_sel (digit_sel)
   );

   always #5 clk = ~clk;

   task automatic applyStimulus(input logic r, input logic e, input logic u,
                                input logic c, input logic l, input logic [15:0] lv);
      reset_n  = r;
      en       = e;
      up       = u;
      clear    = c;
      load     = l;
      load_val = lv;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic addVec(input logic r, input logic e, input logic u, input logic c, input logic l,
                         input logic [15:0] lv, input logic [15:0] ec, input logic ecy);
      vec_t v;
      v.rst_n = r; v.en = e; v.up = u; v.clear = c; v.load = l;
      v.load_val = lv; v.exp_count = ec; v.exp_carry = ecy;
      vecs.push_back(v);
   endtask

   function automatic logic [15:0] to_bcd(input int value);
      logic [15:0] r;
      int          v;
      v = value;
      for (int d = 0; d < 4; d++) begin
         r[d*4 +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   initial begin
      reset_n  = 1'b0;
      en       = 1'b1;
      up       = 1'b1;
      clear    = 1'b0;
      load     = 1'b0;
      load_val = '0;

      // rst_n en up clr ld load_val  count    carry
      addVec(0, 1, 1, 0, 0, 16'h0000, 16'h0000, 0);
      addVec(0, 1, 1, 0, 0, 16'h0000, 16'h0000, 0);
      addVec(1, 1, 1, 1, 1, 16'h12F4, 16'h0000, 0);
      addVec(1, 1, 1, 0, 1, 16'h12F4, 16'h1294, 0);
      addVec(1, 0, 1, 0, 1, 16'h9999, 16'h9999, 0);
      addVec(1, 1, 1, 0, 0, 16'h0000, 16'h9999, 0);
      addVec(1, 1, 1, 0, 0, 16'h0000, 16'h9999, 0);
      addVec(1, 1, 1, 0, 0, 16'h0000, 16'h9999, 0);
      addVec(1, 1, 1, 0, 0, 16'h0000, 16'h0000, 1);
      addVec(1, 1, 1, 0, 0, 16'h0000, 16'h0000, 0);
      addVec(1, 1, 0, 0, 0, 16'h0000, 16'h0000, 0);
      addVec(1, 1, 0, 0, 0, 16'h0000, 16'h0000, 0);
      addVec(1, 1, 0, 0, 0, 16'h0000, 16'h9999, 1);
      addVec(1, 0, 0, 0, 0, 16'h0000, 16'h9999, 0);
      addVec(1, 0, 0, 0, 0, 16'h0000, 16'h9999, 0);
      addVec(1, 1, 1, 0, 1, 16'h0009, 16'h0009, 0);
      addVec(1, 1, 1, 0, 0, 16'h0000, 16'h0009, 0);
      addVec(1, 1, 1, 0, 0, 16'h0000, 16'h0009, 0);
      addVec(1, 1, 1, 0, 0, 16'h0000, 16'h0009, 0);
      addVec(1, 1, 1, 0, 0, 16'h0000, 16'h0010, 0);
      addVec(1, 1, 1, 1, 0, 16'h0000, 16'h0000, 0);
      addVec(1, 1, 1, 0, 0, 16'h0000, 16'h0000, 0);
      addVec(1, 1, 1, 0, 0, 16'h0000, 16'h0000, 0);
      addVec(1, 0, 1, 0, 0, 16'h0000, 16'h0000, 0);
      addVec(1, 0, 1, 0, 0, 16'h0000, 16'h0000, 0);
      addVec(1, 1, 1, 0, 0, 16'h0000, 16'h0000, 0);
      addVec(1, 1, 1, 0, 0, 16'h0000, 16'h0001, 0);

      foreach (vecs[k]) begin
         applyStimulus(vecs[k].rst_n, vecs[k].en, vecs[k].up, vecs[k].clear,
                       vecs[k].load, vecs[k].load_val);
         checkOutput($sformatf("vec%0d_count", k), 32'(count), 32'(vecs[k].exp_count));
         checkOutput($sformatf("vec%0d_carry", k), 32'(carry), 32'(vecs[k].exp_carry));
      end

      $display("[TB] reset then 40-cycle up count");
      for (int n = 0; n < 2; n++) begin
         applyStimulus(0, 1, 1, 0, 0, 16'h0000);
         checkOutput("rst_count", 32'(count), 32'h0000);
         checkOutput("rst_bcd", 32'(bcd), 32'h0);
         checkOutput("rst_sel", 32'(digit_sel), 32'b0001);
         checkOutput("rst_carry", 32'(carry), 32'h0);
      end
      for (int n = 1; n <= 40; n++) begin
         applyStimulus(1, 1, 1, 0, 0, 16'h0000);
         checkOutput($sformatf("up_count_%0d", n), 32'(count), 32'(to_bcd(n / 4)));
         checkOutput($sformatf("up_carry_%0d", n), 32'(carry), 32'h0);
      end
      checkOutput("up_final", 32'(count), 32'h0010);

      $display("[TB] scan of held 4321");
      applyStimulus(0, 0, 1, 0, 0, 16'h0000);
      applyStimulus(1, 0, 1, 0, 1, 16'h4321);
      checkOutput("scan_load_count", 32'(count), 32'h4321);
      checkOutput("scan_load_bcd", 32'(bcd), 32'h0);
      checkOutput("scan_load_sel", 32'(digit_sel), 32'b0001);
      for (int k = 2; k <= 17; k++) begin
         int p;
         applyStimulus(1, 0, 1, 0, 0, 16'h0000);
         p = ((k - 1) / 2) % 4;
         checkOutput($sformatf("scan_bcd_%0d", k), 32'(bcd), 32'(p + 1));
         checkOutput($sformatf("scan_sel_%0d", k), 32'(digit_sel), 32'(1 << p));
      end

      $display("[TB] reset during step cycle");
      applyStimulus(1, 0, 1, 0, 1, 16'h0009);
      checkOutput("mid_load", 32'(count), 32'h0009);
      for (int n = 0; n < 3; n++) begin
         applyStimulus(1, 1, 1, 0, 0, 16'h0000);
         checkOutput("mid_pre", 32'(count), 32'h0009);
      end
      applyStimulus(0, 1, 1, 0, 0, 16'h0000);
      checkOutput("mid_rst_count", 32'(count), 32'h0000);
      checkOutput("mid_rst_carry", 32'(carry), 32'h0);
      checkOutput("mid_rst_bcd", 32'(bcd), 32'h0);
      checkOutput("mid_rst_sel", 32'(digit_sel), 32'b0001);
      applyStimulus(1, 1, 1, 0, 0, 16'h0000);
      checkOutput("post_rst_carry", 32'(carry), 32'h0);
      checkOutput("post_rst_sel", 32'(digit_sel), 32'b0001);
      for (int n = 2; n <= 4; n++) begin
         applyStimulus(1, 1, 1, 0, 0, 16'h0000);
         checkOutput($sformatf("post_rst_count_%0d", n), 32'(count), 32'(to_bcd(n / 4)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
